// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Host-side bus initiator for debug and loading. Parses a byte command stream
//   from the UART receiver and issues single XLEN-bit load/store cycles on the
//   memory-mapped bus. Bus ownership is arbitrated against the cpu via
//   bus_req/bus_gnt. Response bytes go back to the UART transmitter.
//
//   Commands (multi-byte fields little-endian, A = D = XLEN/8 bytes):
//     0x57 'W' A D -> one store cycle, reply 0x4B 'K'
//     0x52 'R' A   -> one load cycle,  reply D bytes of load data
//     other opcode -> reply 0x3F '?'
//
//   Optional feature macro: UART_BUS_BRIDGE_CSUM_EN
//     When defined, every command carries one trailing checksum byte. This byte
//     is the XOR of all preceding command bytes. A mismatch replies 0xEE and
//     issues no bus cycle. A read reply then carries one extra byte: the XOR of
//     the data bytes.
//
// Ports
//   clock       in   1     system clock
//   reset       in   1     synchronous reset, active-high
//   rx_valid    in   1     one-cycle strobe, rx_data holds a received byte
//   rx_data     in   8     received byte
//   tx_valid    out  1     response byte available on tx_data
//   tx_ready    in   1     transmitter accepts tx_data when tx_valid & tx_ready
//   tx_data     out  8     response byte
//   bus_req     out  1     request bus ownership
//   bus_gnt     in   1     bus granted
//   mem_load    out  1     load strobe
//   mem_store   out  1     store strobe
//   address     out  XLEN  byte address
//   store_data  out  XLEN  write data
//   load_data   in   XLEN  read data
module uart_bus_bridge #(
    parameter int XLEN         = 32,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 2500000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [7:0]      tx_data,
    output logic            bus_req,
    input  logic            bus_gnt,
    output logic            mem_load,
    output logic            mem_store,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_data
);

    localparam int NB = XLEN / 8;
    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef UART_BUS_BRIDGE_CSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CSUM, S_REQ, S_ACCESS, S_RESP
    } state_t;
    localparam int RESP_READ_LEN = NB + 1;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_REQ, S_ACCESS, S_RESP
    } state_t;
    localparam int RESP_READ_LEN = NB;
`endif

    state_t            state_reg, state_next;
    logic              is_write_reg, is_write_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [XLEN-1:0]   addr_reg, addr_next;
    logic [XLEN-1:0]   data_reg, data_next;
    logic [XLEN+7:0]   resp_reg, resp_next;
    logic [TW-1:0]     tout_reg, tout_next;
    logic [1:0]        lat_reg, lat_next;
    logic [XLEN+7:0]   read_reply;
    state_t            fields_done;

`ifdef UART_BUS_BRIDGE_CSUM_EN
    logic [7:0]        csum_reg, csum_next;
    logic [7:0]        load_xor [NB+1];

    // XOR of the load data bytes, appended to the read reply.
    assign load_xor[0] = 8'h00;
    for (genvar gi = 0; gi < NB; gi++) begin : g_load_xor
        assign load_xor[gi+1] = load_xor[gi] ^ load_data[8*gi +: 8];
    end

    assign read_reply  = {load_xor[NB], load_data};
    assign fields_done = S_CSUM;
`else
    assign read_reply  = {8'h00, load_data};
    assign fields_done = S_REQ;
`endif

    wire in_cmd   = (state_reg == S_ADDR) || (state_reg == S_DATA)
`ifdef UART_BUS_BRIDGE_CSUM_EN
                    || (state_reg == S_CSUM)
`endif
                    ;
    wire timed_out = (tout_reg == TW'(TIMEOUT));

    always_comb begin
        state_next    = state_reg;
        is_write_next = is_write_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        resp_next     = resp_reg;
        lat_next      = lat_reg;
`ifdef UART_BUS_BRIDGE_CSUM_EN
        csum_next     = csum_reg;
`endif
        // Idle-gap counter only runs while a command is being collected.
        tout_next     = (in_cmd && !rx_valid) ? tout_reg + 1'b1 : '0;

        case (state_reg)
            S_IDLE: begin
                if (rx_valid) begin
                    cnt_next = '0;
`ifdef UART_BUS_BRIDGE_CSUM_EN
                    csum_next = rx_data;
`endif
                    if (rx_data == 8'h57) begin
                        is_write_next = 1'b1;
                        state_next    = S_ADDR;
                    end else if (rx_data == 8'h52) begin
                        is_write_next = 1'b0;
                        state_next    = S_ADDR;
                    end else begin
                        resp_next  = {{XLEN{1'b0}}, 8'h3F};
                        cnt_next   = 4'd1;
                        state_next = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    // Little-endian: the first byte ends up in the LSBs.
                    addr_next = {rx_data, addr_reg[XLEN-1:8]};
`ifdef UART_BUS_BRIDGE_CSUM_EN
                    csum_next = csum_reg ^ rx_data;
`endif
                    if (cnt_reg == 4'(NB - 1)) begin
                        cnt_next   = '0;
                        lat_next   = '0;
                        state_next = is_write_reg ? S_DATA : fields_done;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else if (timed_out) begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    data_next = {rx_data, data_reg[XLEN-1:8]};
`ifdef UART_BUS_BRIDGE_CSUM_EN
                    csum_next = csum_reg ^ rx_data;
`endif
                    if (cnt_reg == 4'(NB - 1)) begin
                        cnt_next   = '0;
                        lat_next   = '0;
                        state_next = fields_done;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else if (timed_out) begin
                    state_next = S_IDLE;
                end
            end
`ifdef UART_BUS_BRIDGE_CSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_reg) begin
                        lat_next   = '0;
                        state_next = S_REQ;
                    end else begin
                        resp_next  = {{XLEN{1'b0}}, 8'hEE};
                        cnt_next   = 4'd1;
                        state_next = S_RESP;
                    end
                end else if (timed_out) begin
                    state_next = S_IDLE;
                end
            end
`endif
            S_REQ: begin
                lat_next = '0;
                if (bus_gnt) begin
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus_gnt) begin
                    // Lost the bus: restart the whole access once re-granted.
                    lat_next   = '0;
                    state_next = S_REQ;
                end else if (is_write_reg) begin
                    resp_next  = {{XLEN{1'b0}}, 8'h4B};
                    cnt_next   = 4'd1;
                    state_next = S_RESP;
                end else if (lat_reg == 2'(READ_LATENCY - 1)) begin
                    resp_next  = read_reply;
                    cnt_next   = 4'(RESP_READ_LEN);
                    state_next = S_RESP;
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
            S_RESP: begin
                if (tx_ready) begin
                    resp_next = {8'h00, resp_reg[XLEN+7:8]};
                    if (cnt_reg == 4'd1) begin
                        cnt_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            is_write_reg <= 1'b0;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            resp_reg     <= '0;
            tout_reg     <= '0;
            lat_reg      <= '0;
`ifdef UART_BUS_BRIDGE_CSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            is_write_reg <= is_write_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            resp_reg     <= resp_next;
            tout_reg     <= tout_next;
            lat_reg      <= lat_next;
`ifdef UART_BUS_BRIDGE_CSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    // Strobes are gated by bus_gnt so the bus is never driven without a grant.
    assign tx_valid   = (state_reg == S_RESP);
    assign tx_data    = resp_reg[7:0];
    assign bus_req    = (state_reg == S_REQ) || (state_reg == S_ACCESS);
    assign mem_store  = (state_reg == S_ACCESS) && is_write_reg && bus_gnt;
    assign mem_load   = (state_reg == S_ACCESS) && !is_write_reg && bus_gnt;
    assign address    = bus_req ? addr_reg : '0;
    assign store_data = (bus_req && is_write_reg) ? data_reg : '0;

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;

    localparam int XLEN = 32;
`ifdef UART_BUS_BRIDGE_CSUM_EN
    localparam int RB = 5;
`else
    localparam int RB = 4;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            tx_valid;
    logic            tx_ready = 1'b1;
    logic [7:0]      tx_data;
    logic            bus_req;
    logic            bus_gnt = 1'b1;
    logic            mem_load;
    logic            mem_store;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] load_data = '0;

    uart_bus_bridge #(.XLEN(XLEN), .READ_LATENCY(1), .TIMEOUT(100)) dut (
        .clock(clock), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .mem_load(mem_load), .mem_store(mem_store),
        .address(address), .store_data(store_data), .load_data(load_data)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int store_cnt = 0;
    int load_cnt = 0;
    int viol = 0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [31:0] ld_addr = '0;
    logic [7:0]  txq[$];
    logic [7:0]  cmd_q[$];

    // Bus and transmitter monitor, sampled at the active edge.
    always @(posedge clock) begin
        if (mem_store) begin
            store_cnt++;
            st_addr = address;
            st_data = store_data;
            $display("[TB] store addr=%08h data=%08h", address, store_data);
        end
        if (mem_load) begin
            load_cnt++;
            ld_addr = address;
            $display("[TB] load addr=%08h", address);
        end
        if ((mem_store || mem_load) && !bus_gnt) viol++;
        if (tx_valid && tx_ready) begin
            txq.push_back(tx_data);
            $display("[TB] tx byte %02h", tx_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] txb(input int i);
        if (i < txq.size()) return txq[i];
        return 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd();
        logic [7:0] x;
        x = 8'h00;
        foreach (cmd_q[i]) begin
            send_byte(cmd_q[i]);
            x = x ^ cmd_q[i];
        end
`ifdef UART_BUS_BRIDGE_CSUM_EN
        send_byte(x);
`endif
        cmd_q.delete();
    endtask

    task automatic clear();
        txq.delete();
        store_cnt = 0;
        load_cnt  = 0;
        viol      = 0;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int c;
        c = 0;
        while (txq.size() < n && c < 300) begin
            @(posedge clock); #1;
            c++;
        end
        repeat (3) @(posedge clock);
        #1;
        chk(tag, txq.size(), n);
    endtask

    task automatic wait_tx_valid(input string tag);
        int c;
        c = 0;
        while (!tx_valid && c < 300) begin
            @(posedge clock); #1;
            c++;
        end
        chk(tag, tx_valid, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_mem_store", mem_store, 1'b0);
        chk("rst_mem_load", mem_load, 1'b0);
        chk("rst_address", address, 32'h0);
        chk("rst_store_data", store_data, 32'h0);
        reset = 1'b0;

        // Store 0xDEADBEEF to 0x100
        clear();
        cmd_q = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_cmd();
        wait_tx("w_tx_count", 1);
        chk("w_tx0", txb(0), 8'h4B);
        chk("w_store_cnt", store_cnt, 1);
        chk("w_addr", st_addr, 32'h100);
        chk("w_data", st_data, 32'hDEADBEEF);
        chk("w_load_cnt", load_cnt, 0);
        chk("w_bus_req_after", bus_req, 1'b0);
        chk("w_address_idle", address, 32'h0);

        // Load from 0x100
        clear();
        load_data = 32'h12345678;
        cmd_q = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
        send_cmd();
        wait_tx("r_tx_count", RB);
        chk("r_load_cnt", load_cnt, 1);
        chk("r_addr", ld_addr, 32'h100);
        chk("r_store_cnt", store_cnt, 0);
        chk("r_tx0", txb(0), 8'h78);
        chk("r_tx1", txb(1), 8'h56);
        chk("r_tx2", txb(2), 8'h34);
        chk("r_tx3", txb(3), 8'h12);
`ifdef UART_BUS_BRIDGE_CSUM_EN
        chk("r_tx_csum", txb(4), 8'h08);
`endif

        // Grant withheld for 10 cycles after the store command
        clear();
        bus_gnt = 1'b0;
        cmd_q = '{8'h57, 8'h00, 8'h02, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        send_cmd();
        repeat (10) @(posedge clock);
        #1;
        chk("g_bus_req_wait", bus_req, 1'b1);
        chk("g_no_store_wait", store_cnt, 0);
        chk("g_tx_none_wait", txq.size(), 0);
        bus_gnt = 1'b1;
        wait_tx("g_tx_count", 1);
        chk("g_tx0", txb(0), 8'h4B);
        chk("g_store_cnt", store_cnt, 1);
        chk("g_addr", st_addr, 32'h200);
        chk("g_data", st_data, 32'hCAFEF00D);
        chk("g_no_gnt_viol", viol, 0);

        // Partial command then silence beyond the timeout
        clear();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (150) @(posedge clock);
        #1;
        chk("t_store_cnt", store_cnt, 0);
        chk("t_tx_none", txq.size(), 0);
        chk("t_bus_req", bus_req, 1'b0);
        load_data = 32'hA1B2C3D4;
        cmd_q = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        send_cmd();
        wait_tx("t_r_tx_count", RB);
        chk("t_r_load_cnt", load_cnt, 1);
        chk("t_r_addr", ld_addr, 32'h10);
        chk("t_r_tx0", txb(0), 8'hD4);
        chk("t_r_tx3", txb(3), 8'hA1);

        // Unknown opcode
        clear();
        send_byte(8'h41);
        wait_tx("u_tx_count", 1);
        chk("u_tx0", txb(0), 8'h3F);
        chk("u_no_bus", store_cnt + load_cnt, 0);

        // Response held while the transmitter is busy
        clear();
        tx_ready = 1'b0;
        cmd_q = '{8'h57, 8'h04, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_cmd();
        wait_tx_valid("s_tx_valid_seen");
        chk("s_tx_data", tx_data, 8'h4B);
        repeat (3) @(posedge clock);
        #1;
        chk("s_tx_valid_hold", tx_valid, 1'b1);
        chk("s_tx_data_hold", tx_data, 8'h4B);
        tx_ready = 1'b1;
        wait_tx("s_tx_count", 1);
        chk("s_store_data", st_data, 32'h44332211);

        // Reset in the middle of a read reply
        clear();
        tx_ready = 1'b0;
        load_data = 32'h12345678;
        cmd_q = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
        send_cmd();
        wait_tx_valid("m_tx_valid_seen");
        tx_ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        tx_ready = 1'b0;
        chk("m_two_sent", txq.size(), 2);
        chk("m_tx_data_third", tx_data, 8'h34);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("m_tx_valid_rst", tx_valid, 1'b0);
        chk("m_bus_req_rst", bus_req, 1'b0);
        tx_ready = 1'b1;
        clear();
        send_byte(8'h41);
        wait_tx("m_idle_tx_count", 1);
        chk("m_idle_tx0", txb(0), 8'h3F);

`ifdef UART_BUS_BRIDGE_CSUM_EN
        // Explicit checksum vectors
        clear();
        load_data = 32'h12345678;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h53);
        wait_tx("c_ok_tx_count", 5);
        chk("c_ok_load", load_cnt, 1);
        chk("c_ok_csum", txb(4), 8'h08);
        clear();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_tx("c_bad_tx_count", 1);
        chk("c_bad_tx0", txb(0), 8'hEE);
        chk("c_bad_no_load", load_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
